// File: rtl/sim_top.sv
// ----------------------------------------------------------------------------
// sim_top
//
// Purpose:
//   Small simulation "SoC top". After reset it prints a boot banner over a
//   byte-wide UART output, then polls a UART input every 16 cycles and
//   echoes any received character. It also keeps a free-running cycle
//   counter plus transmit/receive performance counters. Those counters can
//   be cleared or dumped from outside. A cycle-windowed log traces every
//   transmitted byte.
//
// Ports:
//   clock                  rising-edge clock for all state
//   reset                  synchronous, active-low reset
//   io_logCtrl_log_begin   first cycle-counter value of the log window
//   io_logCtrl_log_end     end of the log window (exclusive)
//   io_logCtrl_log_level   log verbosity, 0 disables logging
//   io_perfInfo_clean      clear the tx/rx performance counters
//   io_perfInfo_dump       print cycle/tx/rx counters
//   io_uart_out_valid      io_uart_out_ch holds a byte to print this cycle
//   io_uart_out_ch         transmitted byte
//   io_uart_in_valid       read request, io_uart_in_ch sampled at next edge
//   io_uart_in_ch          received byte, 8'hFF means no character
// ----------------------------------------------------------------------------
module sim_top (
    input  logic        clock,
    input  logic        reset,
    input  logic [63:0] io_logCtrl_log_begin,
    input  logic [63:0] io_logCtrl_log_end,
    input  logic [63:0] io_logCtrl_log_level,
    input  logic        io_perfInfo_clean,
    input  logic        io_perfInfo_dump,
    output logic        io_uart_out_valid,
    output logic [7:0]  io_uart_out_ch,
    output logic        io_uart_in_valid,
    input  logic [7:0]  io_uart_in_ch
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        POLL = 2'd1,
        ECHO = 2'd2
    } state_t;

    localparam logic [3:0] LAST_ROM_IDX = 4'd12;

    state_t      r_state;
    state_t      w_stateNext;
    logic [3:0]  r_romIdx;
    logic [3:0]  w_romIdxNext;
    logic [63:0] r_cyc;
    logic [63:0] w_cycNext;
    logic [63:0] r_txCnt;
    logic [63:0] r_rxCnt;
    logic        r_outValid;
    logic        w_outValidNext;
    logic [7:0]  r_outCh;
    logic [7:0]  w_outChNext;
    logic        r_inValid;
    logic        w_inValidNext;
    logic [7:0]  w_romByte;
    logic        w_rxHit;
    logic        w_logActive;

    // Boot banner "SimTop ready\n".
    always_comb begin
        w_romByte = 8'h00;
        case (r_romIdx)
            4'd0:    w_romByte = 8'h53;
            4'd1:    w_romByte = 8'h69;
            4'd2:    w_romByte = 8'h6D;
            4'd3:    w_romByte = 8'h54;
            4'd4:    w_romByte = 8'h6F;
            4'd5:    w_romByte = 8'h70;
            4'd6:    w_romByte = 8'h20;
            4'd7:    w_romByte = 8'h72;
            4'd8:    w_romByte = 8'h65;
            4'd9:    w_romByte = 8'h61;
            4'd10:   w_romByte = 8'h64;
            4'd11:   w_romByte = 8'h79;
            4'd12:   w_romByte = 8'h0A;
            default: w_romByte = 8'h00;
        endcase
    end

    // A request cycle that returns anything other than 8'hFF is a real
    // character; this single flag drives both the echo and the rx counter.
    assign w_rxHit   = r_inValid && (io_uart_in_ch != 8'hFF);
    assign w_cycNext = r_cyc + 64'd1;

    // An empty or inverted window (end <= begin) falls out of the unsigned
    // compare naturally and is never active.
    assign w_logActive = (io_logCtrl_log_level != 64'd0) &&
                         (r_cyc >= io_logCtrl_log_begin) &&
                         (r_cyc <  io_logCtrl_log_end);

    // Next-state and next-output logic. Outputs are computed here and then
    // registered, so no input reaches a port combinationally. The poll
    // request is tied to the cycle counter's value in the coming cycle and
    // only raised if that cycle is spent in POLL, so slots that land in
    // BOOT or ECHO are simply dropped.
    always_comb begin
        w_stateNext    = r_state;
        w_romIdxNext   = r_romIdx;
        w_outValidNext = 1'b0;
        w_outChNext    = r_outCh;
        case (r_state)
            BOOT: begin
                w_outValidNext = 1'b1;
                w_outChNext    = w_romByte;
                if (r_romIdx == LAST_ROM_IDX) begin
                    w_stateNext  = POLL;
                    w_romIdxNext = 4'd0;
                end else begin
                    w_romIdxNext = r_romIdx + 4'd1;
                end
            end
            POLL: begin
                if (w_rxHit) begin
                    w_stateNext    = ECHO;
                    w_outValidNext = 1'b1;
                    w_outChNext    = io_uart_in_ch;
                end
            end
            ECHO: begin
                w_stateNext = POLL;
            end
            default: begin
                w_stateNext  = BOOT;
                w_romIdxNext = 4'd0;
            end
        endcase
        w_inValidNext = (w_stateNext == POLL) && (w_cycNext[3:0] == 4'h0);
    end

    // State and registered UART outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state    <= BOOT;
            r_romIdx   <= 4'd0;
            r_outValid <= 1'b0;
            r_outCh    <= 8'h00;
            r_inValid  <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_romIdx   <= w_romIdxNext;
            r_outValid <= w_outValidNext;
            r_outCh    <= w_outChNext;
            r_inValid  <= w_inValidNext;
        end
    end

    // Cycle counter and performance counters; clean overrides increments.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_cyc   <= 64'd0;
            r_txCnt <= 64'd0;
            r_rxCnt <= 64'd0;
        end else begin
            r_cyc <= w_cycNext;
            if (io_perfInfo_clean) begin
                r_txCnt <= 64'd0;
                r_rxCnt <= 64'd0;
            end else begin
                if (r_outValid) begin
                    r_txCnt <= r_txCnt + 64'd1;
                end
                if (w_rxHit) begin
                    r_rxCnt <= r_rxCnt + 64'd1;
                end
            end
        end
    end

    assign io_uart_out_valid = r_outValid;
    assign io_uart_out_ch    = r_outCh;
    assign io_uart_in_valid  = r_inValid;

`ifndef SYNTHESIS
    // Simulation-only trace and perf report. Values printed are the ones
    // held before the edge, so a simultaneous clean still reports the old
    // counts. Nothing is printed while reset is held.
    always @(posedge clock) begin
        if (reset) begin
            if (w_logActive && r_outValid) begin
                $display("[%0d] UART 0x%02h", r_cyc, r_outCh);
            end
            if (io_perfInfo_dump) begin
                $display("PERF cyc=%0d tx=%0d rx=%0d", r_cyc, r_txCnt, r_rxCnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_sim_top.sv
// ----------------------------------------------------------------------------
// tb_sim_top
//
// Purpose:
//   Self-checking bench for sim_top. Stimulus pushes the expected UART
//   output bytes and poll-request cycles into queues. Monitors pop and
//   compare whenever the DUT raises io_uart_out_valid or io_uart_in_valid.
//
// Ports: none (top-level bench).
// ----------------------------------------------------------------------------
module tb_sim_top;

    logic        clock;
    logic        reset;
    logic [63:0] logBegin;
    logic [63:0] logEnd;
    logic [63:0] logLevel;
    logic        perfClean;
    logic        perfDump;
    logic        uartOutValid;
    logic [7:0]  uartOutCh;
    logic        uartInValid;
    logic [7:0]  uartInCh;

    int          checks = 0;
    int          errors = 0;
    longint      tbCyc  = 0;
    int          logCount = 0;

    longint      expOutCyc[$];
    logic [7:0]  expOutCh[$];
    longint      expInCyc[$];

    logic [7:0]  rom [13] = '{8'h53, 8'h69, 8'h6D, 8'h54, 8'h6F, 8'h70, 8'h20,
                              8'h72, 8'h65, 8'h61, 8'h64, 8'h79, 8'h0A};

    sim_top dut (
        .clock                (clock),
        .reset                (reset),
        .io_logCtrl_log_begin (logBegin),
        .io_logCtrl_log_end   (logEnd),
        .io_logCtrl_log_level (logLevel),
        .io_perfInfo_clean    (perfClean),
        .io_perfInfo_dump     (perfDump),
        .io_uart_out_valid    (uartOutValid),
        .io_uart_out_ch       (uartOutCh),
        .io_uart_in_valid     (uartInValid),
        .io_uart_in_ch        (uartInCh)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference cycle counter, independent of the DUT.
    always @(posedge clock) begin
        if (!reset) tbCyc <= 0;
        else        tbCyc <= tbCyc + 1;
    end

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cyc %0d)", name, actual, expected, tbCyc);
        end
    endtask

    // Output monitor: every valid byte must match the head of the queue.
    always @(negedge clock) begin
        if (uartOutValid === 1'b1) begin
            if (expOutCh.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_out: got ch %02h at cyc %0d, none expected", uartOutCh, tbCyc);
            end else begin
                checkOutput("out_cyc", tbCyc, expOutCyc.pop_front());
                checkOutput("out_ch", uartOutCh, expOutCh.pop_front());
            end
            if (dut.w_logActive) logCount++;
        end
        if (uartInValid === 1'b1) begin
            if (expInCyc.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_in_valid: got pulse at cyc %0d, none expected", tbCyc);
            end else begin
                checkOutput("in_valid_cyc", tbCyc, expInCyc.pop_front());
            end
        end
    end

    task automatic pushBoot(input int count);
        for (int i = 0; i < count; i++) begin
            expOutCyc.push_back(longint'(i + 1));
            expOutCh.push_back(rom[i]);
        end
    endtask

    // Advance to the falling edge inside cycle n, bounded.
    task automatic waitCyc(input longint n);
        for (int i = 0; i < 500; i++) begin
            @(negedge clock);
            if (tbCyc == n) return;
        end
        checks++;
        errors++;
        $display("[TB] FAIL wait_timeout: got cyc %0d expected %0d", tbCyc, n);
    endtask

    // Hold reset for k edges, then verify the reset state of the outputs.
    task automatic applyStimulus(input int k);
        @(negedge clock);
        reset = 1'b0;
        repeat (k) @(negedge clock);
        checkOutput("rst_out_valid", uartOutValid, 0);
        checkOutput("rst_out_ch", uartOutCh, 8'h00);
        checkOutput("rst_in_valid", uartInValid, 0);
        checkOutput("rst_cyc", dut.r_cyc, 0);
    endtask

    initial begin
        reset     = 1'b0;
        logBegin  = 64'd0;
        logEnd    = 64'd0;
        logLevel  = 64'd0;
        perfClean = 1'b0;
        perfDump  = 1'b0;
        uartInCh  = 8'hFF;

        // Banner, idle polls, then one echoed 'A'.
        applyStimulus(3);
        pushBoot(13);
        expInCyc.push_back(16);
        expInCyc.push_back(32);
        reset = 1'b1;
        waitCyc(14);
        checkOutput("idle_valid", uartOutValid, 0);
        checkOutput("hold_ch", uartOutCh, 8'h0A);
        waitCyc(32);
        uartInCh = 8'h41;
        expOutCyc.push_back(33);
        expOutCh.push_back(8'h41);
        waitCyc(33);
        uartInCh = 8'hFF;
        waitCyc(34);
        checkOutput("echo_done_valid", uartOutValid, 0);
        checkOutput("echo_hold_ch", uartOutCh, 8'h41);
        waitCyc(40);
        checkOutput("tx_cnt_echo", dut.r_txCnt, 14);
        checkOutput("rx_cnt_echo", dut.r_rxCnt, 1);
        checkOutput("no_log_default", logCount, 0);

        // Reset in the middle of the banner restarts it from byte 0.
        applyStimulus(2);
        pushBoot(5);
        reset = 1'b1;
        waitCyc(5);
        reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        checkOutput("mid_rst_valid", uartOutValid, 0);
        checkOutput("mid_rst_ch", uartOutCh, 8'h00);
        pushBoot(13);
        expInCyc.push_back(16);
        reset = 1'b1;

        // Clean and dump together: old values reported, then cleared.
        waitCyc(20);
        checkOutput("tx_cnt_pre_clean", dut.r_txCnt, 13);
        checkOutput("rx_cnt_pre_clean", dut.r_rxCnt, 0);
        perfClean = 1'b1;
        perfDump  = 1'b1;
        @(negedge clock);
        perfClean = 1'b0;
        perfDump  = 1'b0;
        checkOutput("tx_cnt_clean", dut.r_txCnt, 0);
        checkOutput("rx_cnt_clean", dut.r_rxCnt, 0);

        // Log window [3,6) covers exactly three banner bytes.
        logLevel = 64'd1;
        logBegin = 64'd3;
        logEnd   = 64'd6;
        logCount = 0;
        applyStimulus(2);
        pushBoot(13);
        reset = 1'b1;
        waitCyc(14);
        checkOutput("log_lines", logCount, 3);
        checkOutput("log_idle_valid", uartOutValid, 0);

        checkOutput("out_queue_empty", expOutCh.size(), 0);
        checkOutput("in_queue_empty", expInCyc.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
